// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and presents the fetched word to Decode.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ISSUE   | strobe a request for pc_q this cycle
// WAIT    | one live request outstanding, waiting for rvalid
// HOLD    | instruction valid on InstrF, waiting for Decode to take it
// DISCARD | outstanding request made stale by a redirect; drop its data
module fetch_unit #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallF,
    input  logic         PCSrcE,
    input  logic [N-1:0] PCTargetE,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_rvalid,
    output logic [N-1:0] InstrF,
    output logic [N-1:0] PCF,
    output logic [N-1:0] PCPlus4F,
    output logic         ValidF
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] inst_q, inst_d;
    logic [N-1:0] pc_plus4;
    logic         req_c;

    assign pc_plus4 = pc_q + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        req_c     = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            ISSUE: begin
                req_c   = 1'b1;
                state_d = WAIT;
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = DISCARD;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = imem_rvalid ? ISSUE : DISCARD;
                end else if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Next request goes out in the same cycle the held word is consumed.
                imem_addr = pc_plus4;
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = ISSUE;
                end else if (!StallF) begin
                    req_c   = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = WAIT;
                end
            end
            DISCARD: begin
                if (PCSrcE) pc_d = PCTargetE;
                if (imem_rvalid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    assign imem_req = req_c & ~rst;
    assign ValidF   = (state_q == HOLD);
    assign InstrF   = (state_q == HOLD) ? inst_q : '0;
    assign PCF      = pc_q;
    assign PCPlus4F = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural memory with programmable
// latency answers requests; each step drives inputs and checks outputs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        ValidF;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h98000100 : (a ^ 32'h13000000);
    endfunction

    // Memory: a request seen in cycle t is answered with rvalid in cycle t+lat.
    initial begin : memory
        int cnt;
        logic [31:0] addr_q;
        cnt = 0;
        addr_q = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(addr_q);
                    end
                end
                if (imem_req) begin
                    addr_q = imem_addr;
                    cnt    = lat;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    initial begin
        #1 rst = 1'b1;
        smp();
        chk("rst_valid", {31'b0, ValidF}, 32'h0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_pcplus4", PCPlus4F, 32'h4);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);

        // Sequential fetch, L=1, no stall
        cyc(); rst = 1'b0; smp();
        chk("seq_c0_req", {31'b0, imem_req}, 32'h1);
        chk("seq_c0_addr", imem_addr, 32'h0);
        cyc(); smp();
        chk("seq_c1_req", {31'b0, imem_req}, 32'h0);
        chk("seq_c1_valid", {31'b0, ValidF}, 32'h0);
        cyc(); smp();
        chk("seq_c2_valid", {31'b0, ValidF}, 32'h1);
        chk("seq_c2_pcf", PCF, 32'h0);
        chk("seq_c2_instr", InstrF, 32'h13000000);
        chk("seq_c2_req", {31'b0, imem_req}, 32'h1);
        chk("seq_c2_addr", imem_addr, 32'h4);
        cyc(); smp();
        chk("seq_c3_req", {31'b0, imem_req}, 32'h0);
        cyc(); smp();
        chk("seq_c4_pcf", PCF, 32'h4);
        chk("seq_c4_instr", InstrF, 32'h98000100);
        chk("seq_c4_addr", imem_addr, 32'h8);
        cyc(); smp();
        chk("seq_c5_valid", {31'b0, ValidF}, 32'h0);
        cyc(); smp();
        chk("seq_c6_pcf", PCF, 32'h8);
        chk("seq_c6_instr", InstrF, 32'h13000008);
        chk("seq_c6_addr", imem_addr, 32'hC);

        // Asynchronous reset while in WAIT
        cyc(); #1 rst = 1'b1; #1;
        chk("arst_valid", {31'b0, ValidF}, 32'h0);
        chk("arst_pcf", PCF, 32'h0);
        chk("arst_pcplus4", PCPlus4F, 32'h4);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);

        // Restart, then stall with 0x98000100 held at PC 0x4
        cyc(); rst = 1'b0; smp();
        chk("re_c0_req", {31'b0, imem_req}, 32'h1);
        chk("re_c0_addr", imem_addr, 32'h0);
        cyc(); smp();
        cyc(); smp();
        chk("re_c2_pcf", PCF, 32'h0);
        cyc(); smp();
        for (int i = 0; i < 3; i++) begin
            cyc(); StallF = 1'b1; smp();
            chk("stall_valid", {31'b0, ValidF}, 32'h1);
            chk("stall_instr", InstrF, 32'h98000100);
            chk("stall_pcf", PCF, 32'h4);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
        end
        cyc(); StallF = 1'b0; lat = 3; smp();
        chk("unstall_req", {31'b0, imem_req}, 32'h1);
        chk("unstall_addr", imem_addr, 32'h8);

        // Redirect in WAIT with L=3: stale data must not surface
        cyc(); PCSrcE = 1'b1; PCTargetE = 32'h100; smp();
        chk("rdw_c8_req", {31'b0, imem_req}, 32'h0);
        cyc(); PCSrcE = 1'b0; smp();
        chk("rdw_c9_pcf", PCF, 32'h100);
        chk("rdw_c9_req", {31'b0, imem_req}, 32'h0);
        cyc(); smp();
        chk("rdw_c10_req", {31'b0, imem_req}, 32'h0);
        chk("rdw_c10_valid", {31'b0, ValidF}, 32'h0);
        cyc(); smp();
        chk("rdw_c11_valid", {31'b0, ValidF}, 32'h0);
        chk("rdw_c11_req", {31'b0, imem_req}, 32'h1);
        chk("rdw_c11_addr", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("rdw_wait_valid", {31'b0, ValidF}, 32'h0);
        end

        // Redirect in HOLD while stalled
        cyc(); StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h40; smp();
        chk("rdh_valid", {31'b0, ValidF}, 32'h1);
        chk("rdh_pcf", PCF, 32'h100);
        chk("rdh_instr", InstrF, 32'h13000100);
        chk("rdh_req", {31'b0, imem_req}, 32'h0);
        cyc(); StallF = 1'b0; PCSrcE = 1'b0; lat = 4; smp();
        chk("rdh_next_valid", {31'b0, ValidF}, 32'h0);
        chk("rdh_next_req", {31'b0, imem_req}, 32'h1);
        chk("rdh_next_addr", imem_addr, 32'h40);

        // Two redirects while discarding
        cyc(); PCSrcE = 1'b1; PCTargetE = 32'h200; smp();
        chk("dd_c17_req", {31'b0, imem_req}, 32'h0);
        cyc(); PCTargetE = 32'h300; smp();
        chk("dd_c18_pcf", PCF, 32'h200);
        chk("dd_c18_req", {31'b0, imem_req}, 32'h0);
        cyc(); PCSrcE = 1'b0; smp();
        chk("dd_c19_pcf", PCF, 32'h300);
        chk("dd_c19_req", {31'b0, imem_req}, 32'h0);
        cyc(); smp();
        chk("dd_c20_req", {31'b0, imem_req}, 32'h0);
        cyc(); lat = 1; smp();
        chk("dd_c21_req", {31'b0, imem_req}, 32'h1);
        chk("dd_c21_addr", imem_addr, 32'h300);
        cyc(); smp();
        chk("dd_c22_valid", {31'b0, ValidF}, 32'h0);

        // Wrap-around at the top of the address space
        cyc(); PCSrcE = 1'b1; PCTargetE = 32'hFFFFFFFC; smp();
        chk("wr_hold_pcf", PCF, 32'h300);
        chk("wr_hold_instr", InstrF, 32'h13000300);
        chk("wr_hold_req", {31'b0, imem_req}, 32'h0);
        cyc(); PCSrcE = 1'b0; smp();
        chk("wr_issue_pcf", PCF, 32'hFFFFFFFC);
        chk("wr_issue_pcplus4", PCPlus4F, 32'h0);
        chk("wr_issue_addr", imem_addr, 32'hFFFFFFFC);
        chk("wr_issue_req", {31'b0, imem_req}, 32'h1);
        cyc(); smp();
        cyc(); smp();
        chk("wr_hold2_instr", InstrF, 32'hECFFFFFC);
        chk("wr_hold2_req", {31'b0, imem_req}, 32'h1);
        chk("wr_hold2_addr", imem_addr, 32'h0);

        // Redirect coinciding with rvalid in WAIT: re-issue immediately
        cyc(); PCSrcE = 1'b1; PCTargetE = 32'h80; smp();
        chk("rv_wait_pcf", PCF, 32'h0);
        chk("rv_wait_req", {31'b0, imem_req}, 32'h0);
        cyc(); PCSrcE = 1'b0; smp();
        chk("rv_issue_valid", {31'b0, ValidF}, 32'h0);
        chk("rv_issue_req", {31'b0, imem_req}, 32'h1);
        chk("rv_issue_addr", imem_addr, 32'h80);
        cyc(); smp();
        cyc(); smp();
        chk("rv_hold_pcf", PCF, 32'h80);
        chk("rv_hold_instr", InstrF, 32'h13000080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
